// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first. Each non-idle state lasts
// CLK_DIV clk cycles; hold keeps ss low across back-to-back frames.
module spi_master #(
  parameter int CLK_DIV    = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  hold,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  ss,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_TRAIL,
    S_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    ss_q, ss_d;
  logic                    sck_q, sck_d;
  logic                    done_q, done_d;
  logic                    expire;

  assign expire = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    dout_d    = dout_q;
    ss_d      = ss_q;
    sck_d     = sck_q;
    done_d    = 1'b0;

    // Half-period timer restarts on every state change.
    if (state_q == S_IDLE || expire) div_cnt_d = '0;
    else                             div_cnt_d = div_cnt_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_sr_d   = din;
          ss_d      = 1'b0;
          bit_cnt_d = BIT_LAST;
          state_d   = S_LOW;
        end else if (!ss_q && !hold) begin
          ss_d    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_LOW: begin
        if (expire) begin
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], miso};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (expire) begin
          sck_d = 1'b0;
          if (bit_cnt_q == '0) begin
            state_d = S_TRAIL;
          end else begin
            // mosi is the MSB of tx_sr, so shifting on the falling edge
            // presents the next bit a full half-period before the rise.
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            tx_sr_d   = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
            state_d   = S_LOW;
          end
        end
      end
      S_TRAIL: begin
        if (expire) begin
          dout_d = rx_sr_q;
          done_d = 1'b1;
          if (hold) begin
            state_d = S_IDLE;
          end else begin
            ss_d    = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (expire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      dout_q    <= '0;
      ss_q      <= 1'b1;
      sck_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      dout_q    <= dout_d;
      ss_q      <= ss_d;
      sck_q     <= sck_d;
      done_q    <= done_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign ss   = ss_q;
  assign sck  = sck_q;
  assign mosi = tx_sr_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// Scoreboarded bench for spi_master: stimulus queues expected bytes/bits,
// a negedge monitor checks done/dout, mosi per rising sck and ss/sck rules.
module tb_spi_master;
  localparam int CLK_DIV = 2;
  localparam int LAT     = 17 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       busy, done, ss, sck, mosi, miso;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;          // 0 loopback, 1 miso=1, 2 miso=0, 3 slave model
  int ss_rises = 0;
  logic [7:0] slave_byte = 8'hAA;
  logic       s_miso = 1'b0;

  typedef struct {
    logic [7:0] d;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  logic       exp_bits[$];
  logic [7:0] slave_rx[$];

  assign miso = (mode == 0) ? mosi : (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : s_miso;

  spi_master #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .hold (hold),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .done (done),
    .ss   (ss),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_dout(input int m, input logic [7:0] d);
    case (m)
      0:       return d;
      1:       return 8'hFF;
      2:       return 8'h00;
      default: return slave_byte;
    endcase
  endfunction

  // Monitor: everything the DUT presents is checked here against the queues.
  initial begin
    exp_t e;
    logic b;
    logic sck_p, ss_p;
    sck_p = 1'b0;
    ss_p  = 1'b1;
    forever begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: dout=%0h with no frame pending", dout);
        end else begin
          e = exp_q.pop_front();
          check("dout", 32'(dout), 32'(e.d));
          check("done_latency", cyc - e.acc, LAT);
        end
      end
      if (sck && !sck_p) begin
        if (exp_bits.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sck_rise: mosi=%0b with no bit pending", mosi);
        end else begin
          b = exp_bits.pop_front();
          check("mosi_bit", 32'(mosi), 32'(b));
        end
      end
      if (sck !== sck_p) check("sck_toggle_with_ss_high", 32'(ss_p && ss), 0);
      if (ss !== ss_p)   check("ss_change_with_sck_high", 32'(sck_p && sck), 0);
      if (ss && !ss_p) ss_rises++;
      sck_p = sck;
      ss_p  = ss;
    end
  end

  // Behavioural mode-0 slave: shifts slave_byte out, collects mosi bytes.
  initial begin
    logic ssp, sckp;
    int bc;
    logic [7:0] sr;
    ssp = 1'b1; sckp = 1'b0; bc = 0; sr = 8'h00;
    forever begin
      @(ss or sck);
      if (ssp && !ss) begin
        bc = 0;
        s_miso = slave_byte[7];
      end
      if (!sckp && sck) begin
        sr = {sr[6:0], mosi};
        bc++;
        if (bc == 8) begin
          slave_rx.push_back(sr);
          bc = 0;
        end
      end
      if (sckp && !sck) s_miso = slave_byte[3'(7 - bc)];
      ssp = ss;
      sckp = sck;
    end
  end

  task automatic do_start(input logic [7:0] d, input logic h);
    exp_t e;
    din = d; hold = h; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_accepted", 32'(busy), 1);
    if (busy) begin
      e.d = ref_dout(mode, d);
      e.acc = cyc;
      exp_q.push_back(e);
      for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
    end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout, done=%0b required 1", done);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle", 32'(busy), 0);
  endtask

  task automatic wait_sck_rises(input int n);
    int c = 0;
    logic p;
    p = sck;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sck && !p) c++;
      p = sck;
      if (c == n) break;
    end
    check("sck_rises", c, n);
  endtask

  initial begin
    int n;
    int r0;
    logic [7:0] d;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss", 32'(ss), 1);
    check("rst_sck", 32'(sck), 0);
    check("rst_mosi", 32'(mosi), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_dout", 32'(dout), 0);
    rst = 1'b1;
    @(negedge clk);

    // Loopback 0xA5, then deselect gap length
    mode = 0;
    do_start(8'hA5, 1'b0);
    wait_done();
    check("gap_ss", 32'(ss), 1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check("gap_len", n, CLK_DIV);
    check("post_gap_ss", 32'(ss), 1);

    // Constant miso levels
    mode = 1;
    do_start(8'h00, 1'b0);
    wait_done();
    wait_idle();
    mode = 2;
    do_start(8'h00, 1'b0);
    wait_done();
    wait_idle();

    // Held burst 0x55 then 0x3C
    mode = 0;
    r0 = ss_rises;
    do_start(8'h55, 1'b1);
    wait_done();
    check("burst_ss_held", 32'(ss), 0);
    do_start(8'h3C, 1'b0);
    wait_done();
    wait_idle();
    check("burst_ss_rises", ss_rises - r0, 1);

    // start while busy is ignored
    do_start(8'h12, 1'b0);
    wait_sck_rises(3);
    din = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    wait_idle();
    repeat (4 * CLK_DIV) @(negedge clk);

    // Reset during the 5th bit while sck is high
    do_start(8'hC3, 1'b0);
    wait_sck_rises(5);
    check("pre_rst_sck", 32'(sck), 1);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ss", 32'(ss), 1);
    check("midrst_sck", 32'(sck), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_dout", 32'(dout), 0);
    rst = 1'b1;
    exp_q.delete();
    exp_bits.delete();
    repeat (LAT + 5) @(negedge clk);
    do_start(8'h81, 1'b0);
    wait_done();
    wait_idle();

    // Against the slave model: held burst, slave replies 0xAA
    mode = 3;
    slave_rx.delete();
    do_start(8'h55, 1'b1);
    wait_done();
    do_start(8'h3C, 1'b0);
    wait_done();
    wait_idle();
    check("slave_rx_count", slave_rx.size(), 2);
    if (slave_rx.size() == 2) begin
      check("slave_rx0", 32'(slave_rx[0]), 32'h55);
      check("slave_rx1", 32'(slave_rx[1]), 32'h3C);
    end

    // Random frames
    for (int k = 0; k < 10; k++) begin
      mode = int'($urandom_range(0, 2));
      d = 8'($urandom);
      do_start(d, 1'b0);
      wait_done();
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("pending_frames", exp_q.size(), 0);
    check("pending_bits", exp_bits.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, 8-bit frames, counterpart to spi_slave.
- Drives ss, sck and mosi from a byte handed over on a start strobe.
- Captures miso into dout and pulses done per byte.
- Optional hold input keeps ss asserted for back-to-back bursts; used by the host-side controller to feed the accelerator's SPI port.

Parameters:
- CLK_DIV, 2, clk cycles per sck half-period; legal range ≥1.
- DATA_WIDTH, 8, frame width in bits; the bench and spi_slave use 8.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- hold  input  1  sampled at end of frame; 1 keeps ss low after the byte.
- din  input  DATA_WIDTH  byte to transmit; latched on the accepting edge.
- dout  output  DATA_WIDTH  last received byte; updated with done.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at frame completion.
- ss  output  1  slave select, active low.
- sck  output  1  serial clock; idles low.
- mosi  output  1  serial data out.
- miso  input  1  serial data in.

Behaviour:
- Reset (rst=0 at an edge): state IDLE, ss=1, sck=0, mosi=0, busy=0, done=0, dout=0, counters cleared.
  - Applies mid-frame too: the partial byte is discarded and done is not pulsed.
- States: IDLE, LOW, HIGH, TRAIL, GAP. Every non-IDLE state lasts exactly CLK_DIV cycles, timed by div_cnt counting 0..CLK_DIV-1.
- IDLE:
  - On start=1: tx_sr<=din, ss<=0, mosi<=din[MSB], bit_cnt<=DATA_WIDTH-1, go LOW.
  - Else, if ss=0 (held from the previous frame) and hold=0: ss<=1, go GAP.
- LOW: sck=0. On expiry: sck<=1, rx_sr<={rx_sr[DATA_WIDTH-2:0], miso}, go HIGH. miso is sampled on the same edge that raises sck.
- HIGH: sck=1. On expiry: sck<=0.
  - If bit_cnt=0: go TRAIL.
  - Else: bit_cnt--, mosi<=next lower bit, go LOW.
  - mosi changes only on falling sck and is stable a full half-period before each rising edge.
- TRAIL: sck=0, ss=0. On expiry: dout<=rx_sr, done<=1 for one cycle.
  - If hold=1: ss stays 0, go IDLE.
  - Else: ss<=1, go GAP.
- GAP: ss=1, minimum deselect time of CLK_DIV cycles, then IDLE.
- Latency:
  - Accepting edge E0; done is high during the cycle after edge E0+17*CLK_DIV.
  - Next start accepted at the earliest on the following edge if hold=1, or after GAP if hold=0.
- start while busy=1 is ignored: no queuing, din not latched.
- start and hold arriving together in IDLE with ss held low: start wins; the frame proceeds with ss already low and no glitch high.
- sck never toggles while ss=1. ss never changes while sck=1.
- CLK_DIV=1: sck = clk/2; all transitions still legal.

Test Plan:
- Loopback (miso tied to mosi), CLK_DIV=2, din=0xA5, hold=0:
  - mosi across the 8 rising sck edges = 1,0,1,0,0,1,0,1.
  - dout=0xA5; done pulse 34 edges after accept.
  - ss high 2 cycles in GAP, then busy=0.
- miso tied 1, din=0x00 → dout=0xFF, mosi constant 0. Repeat with miso tied 0 → dout=0x00.
- Burst with hold=1: din=0x55, then start on the cycle after done with din=0x3C, hold=0 on the second byte.
  - ss stays 0 across both frames.
  - Two done pulses, dout 0x55 then 0x3C (loopback).
  - ss=1 only after the second TRAIL.
- start pulsed with din=0xFF at the 3rd rising sck of a 0x12 frame → ignored; dout=0x12; exactly one done pulse.
- rst=0 during the 5th bit (sck=1) → next edge ss=1, sck=0, busy=0, done never pulses. A fresh start with 0x81 then completes normally with dout=0x81.
- Integration with spi_slave, CLK_DIV=4:
  - spi_slave din=0xAA; master sends 0x55 then 0x3C.
  - Slave dout=0x55 then 0x3C; master dout=0xAA on the first frame.
